// File: rtl/balanca_pkg.sv
// Shared types and constants for the scale's price path: FSM states, product codes, price limits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package balanca_pkg;

    localparam int PRECO_W     = 9;
    localparam int ACC_W       = 10;
    localparam int NUM_DIGITOS = 3;
    localparam int CNT_W       = 2;
    localparam int TIMEOUT_W   = 26;

    localparam logic [PRECO_W-1:0] PRECO_MAX     = 9'd500;
    localparam logic [PRECO_W-1:0] DEF_BANANA    = 9'd120;
    localparam logic [PRECO_W-1:0] DEF_MARACUJA  = 9'd350;
    localparam logic [PRECO_W-1:0] DEF_TANGERINA = 9'd200;
    localparam int                 TIMEOUT_CICLOS = 50_000_000;

    localparam logic [1:0] PROD_NENHUM    = 2'b00;
    localparam logic [1:0] PROD_BANANA    = 2'b01;
    localparam logic [1:0] PROD_MARACUJA  = 2'b10;
    localparam logic [1:0] PROD_TANGERINA = 2'b11;

    typedef enum logic [1:0] {
        REPOUSO = 2'd0,
        ENTRADA = 2'd1,
        ESCRITA = 2'd2
    } estado_t;

    function automatic logic [PRECO_W-1:0] satura(input logic [ACC_W-1:0] valor);
        return (valor > ACC_W'(PRECO_MAX)) ? PRECO_MAX : valor[PRECO_W-1:0];
    endfunction

endpackage

// File: rtl/acumulador_bcd.sv
// Decimal entry accumulator: acc = acc*10 + digit, counts digits, exposes the clamped value.
// Latency: accepted digit reflected in acc/preco_sat one cycle later.
// Backpressure: none; digito_rej flags digits that would be ignored (non-BCD or entry full).
module acumulador_bcd
    import balanca_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               limpa,
    input  logic               digito_vld,
    input  logic [3:0]         digito,
    output logic               digito_rej,
    output logic [CNT_W-1:0]   cnt,
    output logic [PRECO_W-1:0] preco_sat
);

    logic [ACC_W-1:0] acc;

    assign digito_rej = (digito > 4'd9) || (cnt == CNT_W'(NUM_DIGITOS));
    assign preco_sat  = satura(acc);

    // Three digits top out at 999, so the 10-bit accumulator never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (limpa) begin
            acc <= '0;
            cnt <= '0;
        end else if (digito_vld && !digito_rej) begin
            acc <= acc * ACC_W'(10) + ACC_W'(digito);
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/programacao_preco.sv
// Operator price programming: keyed decimal entry, clamped to PRECO_MAX, stored per product.
// Latency: confirma at N -> atualizado at N+1 -> new price visible at N+2. Optional PRECO_TIMEOUT_EN aborts idle entries.
// Backpressure: none; inputs are single-cycle pulses, illegal ones produce an erro pulse.
module programacao_preco
    import balanca_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         produto,
    input  logic               inicia,
    input  logic [3:0]         digito,
    input  logic               digito_valido,
    input  logic               confirma,
    input  logic               cancela,
    output logic [PRECO_W-1:0] preco_banana,
    output logic [PRECO_W-1:0] preco_maracuja,
    output logic [PRECO_W-1:0] preco_tangerina,
    output logic [PRECO_W-1:0] preco_eco,
    output logic               ocupado,
    output logic               atualizado,
    output logic               erro
);

    estado_t            estado;
    logic [1:0]         produto_lat;
    logic               limpa;
    logic               digito_vld_ac;
    logic               digito_rej;
    logic [CNT_W-1:0]   cnt;
    logic [PRECO_W-1:0] preco_sat;
`ifdef PRECO_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] ocioso;
`endif

    assign limpa         = (estado == REPOUSO) && inicia && (produto != PROD_NENHUM);
    // cancela and confirma outrank a digit arriving in the same cycle.
    assign digito_vld_ac = (estado == ENTRADA) && digito_valido && !cancela && !confirma;
    assign preco_eco     = (estado == ENTRADA) ? preco_sat : '0;

    acumulador_bcd u_acumulador (
        .clk        (clk),
        .rst_n      (rst_n),
        .limpa      (limpa),
        .digito_vld (digito_vld_ac),
        .digito     (digito),
        .digito_rej (digito_rej),
        .cnt        (cnt),
        .preco_sat  (preco_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= REPOUSO;
            produto_lat     <= PROD_NENHUM;
            preco_banana    <= DEF_BANANA;
            preco_maracuja  <= DEF_MARACUJA;
            preco_tangerina <= DEF_TANGERINA;
            ocupado         <= 1'b0;
            atualizado      <= 1'b0;
            erro            <= 1'b0;
`ifdef PRECO_TIMEOUT_EN
            ocioso          <= '0;
`endif
        end else begin
            atualizado <= 1'b0;
            erro       <= 1'b0;
            case (estado)
                REPOUSO: begin
                    if (inicia) begin
                        produto_lat <= produto;
                        if (produto == PROD_NENHUM) begin
                            erro <= 1'b1;
                        end else begin
                            estado  <= ENTRADA;
                            ocupado <= 1'b1;
`ifdef PRECO_TIMEOUT_EN
                            ocioso  <= '0;
`endif
                        end
                    end
                end
                ENTRADA: begin
                    if (cancela) begin
                        estado  <= REPOUSO;
                        ocupado <= 1'b0;
                    end else if (confirma) begin
                        if (cnt == '0) begin
                            erro    <= 1'b1;
                            estado  <= REPOUSO;
                            ocupado <= 1'b0;
                        end else begin
                            estado     <= ESCRITA;
                            atualizado <= 1'b1;
                        end
                    end else if (digito_valido) begin
                        erro <= digito_rej;
`ifdef PRECO_TIMEOUT_EN
                        ocioso <= '0;
`endif
                    end
`ifdef PRECO_TIMEOUT_EN
                    else if (ocioso == TIMEOUT_W'(TIMEOUT_CICLOS - 1)) begin
                        erro    <= 1'b1;
                        estado  <= REPOUSO;
                        ocupado <= 1'b0;
                    end else begin
                        ocioso <= ocioso + TIMEOUT_W'(1);
                    end
`endif
                end
                ESCRITA: begin
                    case (produto_lat)
                        PROD_BANANA:    preco_banana    <= preco_sat;
                        PROD_MARACUJA:  preco_maracuja  <= preco_sat;
                        PROD_TANGERINA: preco_tangerina <= preco_sat;
                        default:        ;
                    endcase
                    estado  <= REPOUSO;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= REPOUSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_programacao_preco.sv
// Directed and random price-programming sequences checked against a behavioural entry model.
module tb_programacao_preco;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] produto = 2'b00;
    logic       inicia = 1'b0;
    logic [3:0] digito = 4'd0;
    logic       digito_valido = 1'b0;
    logic       confirma = 1'b0;
    logic       cancela = 1'b0;
    logic [8:0] preco_banana, preco_maracuja, preco_tangerina, preco_eco;
    logic       ocupado, atualizado, erro;

    int checks = 0;
    int errors = 0;

    // Model state: stored prices, whether an entry is open, its digits, and a pending write.
    int m_preco[4];
    bit m_ativo, m_escr;
    int m_prod, m_acc, m_cnt;
    bit e_erro, e_atu;

    always #5 clk = ~clk;

    programacao_preco dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .produto         (produto),
        .inicia          (inicia),
        .digito          (digito),
        .digito_valido   (digito_valido),
        .confirma        (confirma),
        .cancela         (cancela),
        .preco_banana    (preco_banana),
        .preco_maracuja  (preco_maracuja),
        .preco_tangerina (preco_tangerina),
        .preco_eco       (preco_eco),
        .ocupado         (ocupado),
        .atualizado      (atualizado),
        .erro            (erro)
    );

    function automatic int mn(input int a);
        return (a > 500) ? 500 : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic verifica();
        chk("preco_banana", 32'(preco_banana), 32'(m_preco[1]));
        chk("preco_maracuja", 32'(preco_maracuja), 32'(m_preco[2]));
        chk("preco_tangerina", 32'(preco_tangerina), 32'(m_preco[3]));
        chk("ocupado", 32'(ocupado), 32'(m_ativo));
        chk("preco_eco", 32'(preco_eco), 32'((m_ativo && !m_escr) ? mn(m_acc) : 0));
        chk("atualizado", 32'(atualizado), 32'(e_atu));
        chk("erro", 32'(erro), 32'(e_erro));
    endtask

    task automatic reset_modelo();
        m_preco[0] = 0;
        m_preco[1] = 120;
        m_preco[2] = 350;
        m_preco[3] = 200;
        m_ativo = 0;
        m_escr = 0;
        m_acc = 0;
        m_cnt = 0;
        e_erro = 0;
        e_atu = 0;
    endtask

    task automatic aplica_reset();
        rst_n = 1'b0;
        reset_modelo();
        #1;
        verifica();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        verifica();
    endtask

    task automatic ciclo(input bit ini, input logic [1:0] prod, input bit dv,
                         input logic [3:0] d, input bit conf, input bit canc);
        inicia = ini;
        produto = prod;
        digito_valido = dv;
        digito = d;
        confirma = conf;
        cancela = canc;
        e_erro = 0;
        e_atu = 0;
        if (m_escr) begin
            m_preco[m_prod] = mn(m_acc);
            m_escr = 0;
            m_ativo = 0;
        end else if (!m_ativo) begin
            if (ini) begin
                if (prod == 2'b00) e_erro = 1;
                else begin
                    m_ativo = 1;
                    m_prod = int'(prod);
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
        end else if (canc) begin
            m_ativo = 0;
        end else if (conf) begin
            if (m_cnt == 0) begin
                e_erro = 1;
                m_ativo = 0;
            end else begin
                m_escr = 1;
                e_atu = 1;
            end
        end else if (dv) begin
            if (d > 4'd9 || m_cnt == 3) e_erro = 1;
            else begin
                m_acc = m_acc * 10 + int'(d);
                m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        inicia = 1'b0;
        digito_valido = 1'b0;
        confirma = 1'b0;
        cancela = 1'b0;
        verifica();
    endtask

    task automatic inicia_em(input logic [1:0] p);
        ciclo(1, p, 0, 4'd0, 0, 0);
    endtask
    task automatic dig(input logic [3:0] d);
        ciclo(0, 2'b00, 1, d, 0, 0);
    endtask
    task automatic conf();
        ciclo(0, 2'b00, 0, 4'd0, 1, 0);
    endtask
    task automatic ocioso();
        ciclo(0, 2'b00, 0, 4'd0, 0, 0);
    endtask

    initial begin
        reset_modelo();
        @(negedge clk);
        aplica_reset();
        chk("reset_banana_120", 32'(preco_banana), 32'd120);
        chk("reset_maracuja_350", 32'(preco_maracuja), 32'd350);
        chk("reset_tangerina_200", 32'(preco_tangerina), 32'd200);

        inicia_em(2'b01);
        dig(4'd2);
        dig(4'd4);
        dig(4'd5);
        conf();
        chk("atualizado_apos_confirma", 32'(atualizado), 32'd1);
        ocioso();
        chk("banana_245", 32'(preco_banana), 32'd245);
        chk("maracuja_intacta", 32'(preco_maracuja), 32'd350);

        inicia_em(2'b10);
        dig(4'd9);
        dig(4'd9);
        dig(4'd9);
        chk("eco_saturado_500", 32'(preco_eco), 32'd500);
        conf();
        ocioso();
        chk("maracuja_500", 32'(preco_maracuja), 32'd500);

        inicia_em(2'b11);
        dig(4'hA);
        chk("erro_digito_nao_bcd", 32'(erro), 32'd1);
        dig(4'd7);
        conf();
        ocioso();
        chk("tangerina_7", 32'(preco_tangerina), 32'd7);

        inicia_em(2'b11);
        dig(4'd1);
        dig(4'd2);
        ciclo(1, 2'b01, 0, 4'd0, 0, 0);
        dig(4'd3);
        dig(4'd4);
        chk("erro_quarto_digito", 32'(erro), 32'd1);
        chk("eco_123", 32'(preco_eco), 32'd123);
        ciclo(0, 2'b00, 0, 4'd0, 0, 1);
        chk("cancela_sem_escrita", 32'(preco_tangerina), 32'd7);

        inicia_em(2'b00);
        chk("erro_produto_nenhum", 32'(erro), 32'd1);
        chk("ocupado_produto_nenhum", 32'(ocupado), 32'd0);

        inicia_em(2'b01);
        dig(4'd3);
        ciclo(0, 2'b00, 0, 4'd0, 1, 1);
        ocioso();
        chk("cancela_vence_confirma", 32'(preco_banana), 32'd245);

        inicia_em(2'b10);
        conf();
        chk("erro_confirma_vazio", 32'(erro), 32'd1);

        inicia_em(2'b01);
        dig(4'd8);
        aplica_reset();
        chk("reset_meio_banana_120", 32'(preco_banana), 32'd120);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) aplica_reset();
            ciclo($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
